// File: rtl/snoop_pkg.sv
// Shared bus-operation encodings, snoop result / MESI enums and the
// result-to-MESI mapping used by the snoop sequencer.
package snoop_pkg;

    localparam logic [7:0] OP_READ       = 8'd1;
    localparam logic [7:0] OP_WRITE      = 8'd2;
    localparam logic [7:0] OP_INVALIDATE = 8'd3;
    localparam logic [7:0] OP_RWIM       = 8'd4;

    typedef enum logic [1:0] {
        NOHIT = 2'b00,
        HIT   = 2'b01,
        HITM  = 2'b10,
        RSVD  = 2'b11
    } snoop_result_t;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } seq_state_t;

    function automatic logic opIsLegal(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE) ||
               (op == OP_INVALIDATE) || (op == OP_RWIM);
    endfunction

    // Reserved results are expected to be folded to NOHIT by the caller.
    function automatic mesi_t mesiFromSnoop(input logic [7:0] op, input snoop_result_t result);
        mesi_t m;
        m = MESI_I;
        case (op)
            OP_READ:                m = (result == HIT || result == HITM) ? MESI_S : MESI_E;
            OP_RWIM, OP_INVALIDATE: m = MESI_M;
            default:                m = MESI_I;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; used for snoop result statistics.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bus_snoop_sequencer.sv
// Issues one L2 bus operation at a time, holds it for the snoop window,
// samples the snoop result and returns it with the resulting MESI state.
//
// state | meaning
// IDLE  | ready for a request from the L2 controller
// ISSUE | operation driven on the bus, waitCnt counts down the snoop window
// RESP  | result/state presented until the consumer accepts
module bus_snoop_sequencer
    import snoop_pkg::*;
#(
    parameter int addressSize  = 32,
    parameter int snoopLatency = 2,
    parameter int statWidth    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reqValid,
    output logic                   reqReady,
    input  logic [7:0]             reqOp,
    input  logic [addressSize-1:0] reqAddress,
    output logic                   busValid,
    output logic [7:0]             busOperation,
    output logic [addressSize-1:0] busAddress,
    input  logic [1:0]             snoopBus,
    output logic                   respValid,
    input  logic                   respReady,
    output logic [1:0]             respResult,
    output logic [1:0]             respState,
    output logic                   illegalOp,
    output logic                   protocolError,
    output logic [statWidth-1:0]   hitCount,
    output logic [statWidth-1:0]   hitmCount,
    output logic [statWidth-1:0]   nohitCount
);

    localparam logic [3:0] WAIT_LOAD = 4'(snoopLatency - 1);

    seq_state_t                state, stateNext;
    logic [3:0]                waitCnt;
    logic [7:0]                opReg;
    logic [addressSize-1:0]    addrReg;
    snoop_result_t             resultReg;
    mesi_t                     mesiReg;
    logic                      accept, sampleEdge;
    snoop_result_t             sampled, effResult;
    logic                      countable;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        accept     = 1'b0;
        sampleEdge = 1'b0;
        reqReady   = 1'b0;
        busValid   = 1'b0;
        respValid  = 1'b0;
        case (state)
            IDLE: begin
                reqReady = 1'b1;
                if (reqValid) begin
                    accept    = 1'b1;
                    stateNext = opIsLegal(reqOp) ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                busValid = 1'b1;
                if (waitCnt == 4'd0) begin
                    sampleEdge = 1'b1;
                    stateNext  = RESP;
                end
            end
            RESP: begin
                respValid = 1'b1;
                if (respReady) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Reserved encoding is a protocol violation but is scored as NOHIT.
    assign sampled   = snoop_result_t'(snoopBus);
    assign effResult = (sampled == RSVD) ? NOHIT : sampled;
    assign countable = sampleEdge && (opReg != OP_WRITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            opReg         <= '0;
            addrReg       <= '0;
            waitCnt       <= '0;
            resultReg     <= NOHIT;
            mesiReg       <= MESI_I;
            illegalOp     <= 1'b0;
            protocolError <= 1'b0;
        end else begin
            illegalOp     <= 1'b0;
            protocolError <= 1'b0;
            if (accept) begin
                opReg   <= reqOp;
                addrReg <= reqAddress;
                waitCnt <= WAIT_LOAD;
                if (!opIsLegal(reqOp)) begin
                    resultReg <= NOHIT;
                    mesiReg   <= MESI_I;
                    illegalOp <= 1'b1;
                end
            end
            if (state == ISSUE && waitCnt != 4'd0) begin
                waitCnt <= waitCnt - 4'd1;
            end
            if (sampleEdge) begin
                if (opReg == OP_WRITE) begin
                    resultReg <= NOHIT;
                    mesiReg   <= MESI_I;
                end else begin
                    resultReg     <= effResult;
                    mesiReg       <= mesiFromSnoop(opReg, effResult);
                    protocolError <= (sampled == RSVD);
                end
            end
        end
    end

    assign busOperation = opReg;
    assign busAddress   = addrReg;
    assign respResult   = resultReg;
    assign respState    = mesiReg;

    sat_counter #(.WIDTH(statWidth)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (countable && effResult == HIT),
        .count (hitCount)
    );

    sat_counter #(.WIDTH(statWidth)) u_hitm_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (countable && effResult == HITM),
        .count (hitmCount)
    );

    sat_counter #(.WIDTH(statWidth)) u_nohit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (countable && effResult == NOHIT),
        .count (nohitCount)
    );

endmodule

// File: doc/bus_snoop_sequencer.md
# bus_snoop_sequencer

Issues one L2 bus operation at a time onto the snoop interface, holds it for a fixed snoop window, samples the 2-bit snoop result driven back by the snoop-response model, and returns that result plus the MESI state the requesting line must take. It sits between the L2 controller (upstream, valid/ready request) and the snoop-response model (downstream, `busAddress`/`busOperation` in, `snoopBus` out). It also keeps saturating HIT/HITM/NOHIT statistics for the simulator report.

## Interface
- `addressSize`, 32, address width.
- `snoopLatency`, 2, cycles the operation is held on the bus before sampling; legal range 1–15.
- `statWidth`, 32, width of each statistics counter.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `reqValid`  in  1  request present.
- `reqReady`  out  1  sequencer can accept; high only in IDLE.
- `reqOp`  in  8  bus operation: READ=1, WRITE=2, INVALIDATE=3, RWIM=4.
- `reqAddress`  in  addressSize  line address.
- `busValid`  out  1  operation on the bus.
- `busOperation`  out  8  registered copy of `reqOp`.
- `busAddress`  out  addressSize  registered copy of `reqAddress`.
- `snoopBus`  in  2  result: 00 NOHIT, 01 HIT, 10 HITM, 11 reserved.
- `respValid`  out  1  response present.
- `respReady`  in  1  consumer accepts the response.
- `respResult`  out  2  sampled snoop result.
- `respState`  out  2  MESI state for the line: I=0, S=1, E=2, M=3.
- `illegalOp`  out  1  one-cycle pulse when an unknown op is accepted.
- `protocolError`  out  1  one-cycle pulse when 11 is sampled.
- `hitCount`, `hitmCount`, `nohitCount`  out  statWidth  saturating counts of the sampled results.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - `reqReady`=1.
  - On `reqValid`: latch op and address.
  - Legal op: go to ISSUE and load `waitCnt`=snoopLatency-1.
  - Illegal op: go to RESP with result 00 and state I, pulse `illegalOp`; no bus activity.
- **ISSUE**
  - `busValid`=1; `busOperation`/`busAddress` held stable.
  - While `waitCnt`≠0: decrement `waitCnt`.
  - When `waitCnt`=0: sample `snoopBus` on that edge and go to RESP.
- State mapping:
  - READ: NOHIT→E, HIT→S, HITM→S.
  - RWIM and INVALIDATE: M regardless of result.
  - WRITE (writeback): result forced to NOHIT, state I; the sample is ignored and no statistics are updated.
- Sampled 11 (READ, RWIM, INVALIDATE):
  - Treated as NOHIT for both result and state mapping.
  - `protocolError` pulses.
  - `nohitCount` increments.
- Statistics:
  - One counter increments per sampled READ, RWIM or INVALIDATE.
  - Counters saturate at all-ones.
- **RESP**
  - `respValid`=1; `respResult`/`respState` held stable.
  - Leave on `respValid`&&`respReady`, back to IDLE.
  - A new request can be accepted no earlier than the cycle after the response handshake; there is no overlap.

## Timing
- Reset values:
  - State IDLE.
  - `reqReady`=1 on the first cycle after reset.
  - `busValid`=0, `busOperation`=0, `busAddress`=0.
  - `respValid`=0, `respResult`=00, `respState`=I.
  - Pulses 0, all counters 0.
- Request accepted at edge N (IDLE):
  - `busValid` is high for cycles N+1 … N+snoopLatency.
  - `snoopBus` is sampled at the edge ending cycle N+snoopLatency.
  - `respValid` rises in cycle N+snoopLatency+1.
- Illegal op accepted at edge N: `respValid` and `illegalOp` in cycle N+1.
- `respReady` already high when `respValid` rises: response lasts exactly one cycle, `reqReady` returns the following cycle.
- Reset asserted mid-operation, including during ISSUE or RESP:
  - Next edge forces all reset values.
  - The in-flight request is dropped with no response.
  - `busValid` falls.
- `snoopBus` is only observed at the sampling edge; its value in other cycles has no effect.

## Structure
- `snoop_pkg` holds:
  - bus-op constants (READ/WRITE/INVALIDATE/RWIM);
  - `snoop_result_t` enum (NOHIT/HIT/HITM/RSVD);
  - `mesi_t` enum (I/S/E/M);
  - `seq_state_t` FSM enum;
  - a `mesiFromSnoop(op, result)` function.
- Sub-module `sat_counter` (parameter WIDTH; ports `clk`, `reset`, `inc`, `count`) is instantiated three times.

## Test plan
- READ at address 32'h0000_1000, snoopLatency=2, `snoopBus`=00 at the sampling edge → `busValid` high 2 cycles; response result 00, state E, 3 cycles after accept; `nohitCount`=1.
- READ with 01, then READ with 10, `respReady` tied high → states S, S; `hitCount`=1, `hitmCount`=1; `reqReady` low throughout each transaction.
- RWIM with 10 → state M, result 10; INVALIDATE with 00 → state M; WRITE with 10 on the bus → result 00, state I, no counter changes.
- `reqOp`=8'h07 → no `busValid`; `respValid` and `illegalOp` next cycle, state I; `snoopBus`=11 on a READ → `protocolError` pulse, state E, `nohitCount`+1.
- Backpressure: `respReady` low 5 cycles → outputs stable and `reqReady` stays 0; reset in ISSUE cycle 1 → next cycle `busValid`=0, `respValid`=0, counters 0, `reqReady`=1.
- Saturation with statWidth=4: 17 NOHIT READs → `nohitCount`=4'hF.
